// File: rtl/pa_pkg.sv
// Shared widths and fetch-state encoding for the PA core front end.
package pa_pkg;

    localparam int unsigned INSTR_WIDTH = 60;
    localparam int unsigned ADDR_WIDTH  = 16;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MISS   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pa_icache_store.sv
// Direct-mapped tagged instruction store: combinational read with same-cycle
// write bypass, synchronous write, valid bits cleared on reset.
module pa_icache_store
    import pa_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   write_en,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic [INSTR_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0]  read_addr,
    output logic                   hit,
    output logic [INSTR_WIDTH-1:0] read_data
);

    localparam int unsigned DEPTH    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS;

    logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_BITS-1:0]    tag_mem  [DEPTH];
    logic [DEPTH-1:0]       valid_bits;

    logic [INDEX_BITS-1:0]  write_idx;
    logic [INDEX_BITS-1:0]  read_idx;
    logic [TAG_BITS-1:0]    write_tag;
    logic [TAG_BITS-1:0]    read_tag;
    logic                   bypass;

    assign write_idx = write_addr[INDEX_BITS-1:0];
    assign write_tag = write_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign read_idx  = read_addr[INDEX_BITS-1:0];
    assign read_tag  = read_addr[ADDR_WIDTH-1:INDEX_BITS];

    // Data and tags carry no reset; only the valid bits gate their use.
    always_ff @(posedge clock) begin
        if (write_en) begin
            data_mem[write_idx] <= write_data;
            tag_mem[write_idx]  <= write_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
        end else if (write_en) begin
            valid_bits[write_idx] <= 1'b1;
        end
    end

    always_comb begin
        bypass    = write_en && (write_addr == read_addr);
        hit       = bypass || (valid_bits[read_idx] && (tag_mem[read_idx] == read_tag));
        read_data = bypass ? write_data : data_mem[read_idx];
    end

endmodule

// File: rtl/pa_fetch_unit.sv
// Fetch stage: PC, FETCH/MISS/HALTED control and the registered decode-side
// output with a valid/stall handshake.
module pa_fetch_unit
    import pa_pkg::*;
#(
    parameter int unsigned           INDEX_BITS = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   halt_i,
    input  logic                   icacheWriteEnable_i,
    input  logic [ADDR_WIDTH-1:0]  writeAddress_i,
    input  logic [INSTR_WIDTH-1:0] instruction_i,
    input  logic                   branchValid_i,
    input  logic [ADDR_WIDTH-1:0]  branchTarget_i,
    input  logic                   decodeStall_i,
    output logic                   instrValid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instrPc_o,
    output logic                   halted_o,
    output logic [15:0]            fetchCount_o
);

    fetch_state_e           state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   hit;
    logic [INSTR_WIDTH-1:0] hit_data;
    logic                   adv;
    logic                   miss_fill;

    pa_icache_store #(
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clock      (clock_i),
        .reset      (reset_i),
        .write_en   (icacheWriteEnable_i),
        .write_addr (writeAddress_i),
        .write_data (instruction_i),
        .read_addr  (pc),
        .hit        (hit),
        .read_data  (hit_data)
    );

    assign adv       = !instrValid_o || !decodeStall_i;
    assign miss_fill = icacheWriteEnable_i && (writeAddress_i == pc);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            instrValid_o <= 1'b0;
            instr_o      <= '0;
            instrPc_o    <= '0;
            halted_o     <= 1'b0;
            fetchCount_o <= '0;
        end else begin
            if (instrValid_o && !decodeStall_i) begin
                fetchCount_o <= fetchCount_o + 16'd1;
            end

            if (branchValid_i) begin
                // Redirect flushes any held instruction, stalled or not.
                pc           <= branchTarget_i;
                instrValid_o <= 1'b0;
                if (!(state == HALTED && halt_i)) begin
                    state    <= FETCH;
                    halted_o <= 1'b0;
                end
            end else begin
                unique case (state)
                    FETCH: begin
                        if (adv) begin
                            if (halt_i) begin
                                // Held instruction (if any) leaves on this edge.
                                instrValid_o <= 1'b0;
                                halted_o     <= 1'b1;
                                state        <= HALTED;
                            end else if (hit) begin
                                instr_o      <= hit_data;
                                instrPc_o    <= pc;
                                instrValid_o <= 1'b1;
                                pc           <= pc + 1'b1;
                            end else begin
                                instrValid_o <= 1'b0;
                                state        <= MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (halt_i) begin
                            instrValid_o <= 1'b0;
                            halted_o     <= 1'b1;
                            state        <= HALTED;
                        end else if (miss_fill) begin
                            instr_o      <= instruction_i;
                            instrPc_o    <= pc;
                            instrValid_o <= 1'b1;
                            pc           <= pc + 1'b1;
                            state        <= FETCH;
                        end
                    end
                    HALTED: begin
                        instrValid_o <= 1'b0;
                        if (!halt_i) begin
                            halted_o <= 1'b0;
                            state    <= FETCH;
                        end
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pa_fetch_unit.sv
// Scoreboard bench for pa_fetch_unit: stimulus queues expected deliveries,
// a negedge monitor pops and compares each accepted instruction.
module tb_pa_fetch_unit;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        halt_i;
    logic        icacheWriteEnable_i;
    logic [15:0] writeAddress_i;
    logic [59:0] instruction_i;
    logic        branchValid_i;
    logic [15:0] branchTarget_i;
    logic        decodeStall_i;
    logic        instrValid_o;
    logic [59:0] instr_o;
    logic [15:0] instrPc_o;
    logic        halted_o;
    logic [15:0] fetchCount_o;

    int checks = 0;
    int errors = 0;
    logic [75:0] exp_q[$];

    pa_fetch_unit u_dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .halt_i              (halt_i),
        .icacheWriteEnable_i (icacheWriteEnable_i),
        .writeAddress_i      (writeAddress_i),
        .instruction_i       (instruction_i),
        .branchValid_i       (branchValid_i),
        .branchTarget_i      (branchTarget_i),
        .decodeStall_i       (decodeStall_i),
        .instrValid_o        (instrValid_o),
        .instr_o             (instr_o),
        .instrPc_o           (instrPc_o),
        .halted_o            (halted_o),
        .fetchCount_o        (fetchCount_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push(input logic [15:0] pc, input logic [59:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic write(input logic [15:0] addr, input logic [59:0] data);
        icacheWriteEnable_i = 1'b1;
        writeAddress_i      = addr;
        instruction_i       = data;
        step();
        icacheWriteEnable_i = 1'b0;
    endtask

    task automatic branch(input logic [15:0] target);
        branchValid_i  = 1'b1;
        branchTarget_i = target;
        step();
        branchValid_i  = 1'b0;
    endtask

    // Monitor: every instruction accepted by decode must match the queue head.
    always @(negedge clock_i) begin
        if (!reset_i && instrValid_o && !decodeStall_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver_unexpected actual_pc=%h actual_instr=%h required=none",
                         instrPc_o, instr_o);
            end else begin
                logic [75:0] e;
                e = exp_q.pop_front();
                if ({instrPc_o, instr_o} !== e) begin
                    errors++;
                    $display("FAIL deliver actual_pc=%h actual_instr=%h required_pc=%h required_instr=%h",
                             instrPc_o, instr_o, e[75:60], e[59:0]);
                end
            end
        end
    end

    initial begin
        reset_i             = 1'b1;
        halt_i              = 1'b1;
        icacheWriteEnable_i = 1'b0;
        writeAddress_i      = '0;
        instruction_i       = '0;
        branchValid_i       = 1'b0;
        branchTarget_i      = '0;
        decodeStall_i       = 1'b0;

        repeat (2) @(posedge clock_i);
        #1;
        check("reset_valid", {63'd0, instrValid_o}, 64'd0);
        check("reset_instr", {4'd0, instr_o}, 64'd0);
        check("reset_pc", {48'd0, instrPc_o}, 64'd0);
        check("reset_halted", {63'd0, halted_o}, 64'd0);
        check("reset_count", {48'd0, fetchCount_o}, 64'd0);
        reset_i = 1'b0;

        // Load while halted, then release halt and stream A0..A3.
        write(16'h0000, 60'hA0);
        write(16'h0001, 60'hA1);
        write(16'h0002, 60'hA2);
        write(16'h0003, 60'hA3);
        write(16'hFFFF, 60'hFFF0);
        check("halted_while_loading", {63'd0, halted_o}, 64'd1);
        push(16'h0000, 60'hA0);
        push(16'h0001, 60'hA1);
        push(16'h0002, 60'hA2);
        push(16'h0003, 60'hA3);
        halt_i = 1'b0;
        repeat (8) step();
        check("stream_count", {48'd0, fetchCount_o}, 64'd4);
        check("stream_miss_at_4", {63'd0, instrValid_o}, 64'd0);

        // Stall on A1 for three cycles, then release.
        decodeStall_i = 1'b1;
        branch(16'h0001);
        check("branch_flush", {63'd0, instrValid_o}, 64'd0);
        step();
        check("stall_first_instr", {4'd0, instr_o}, 64'hA1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_instr", {4'd0, instr_o}, 64'hA1);
            check("stall_hold_pc", {48'd0, instrPc_o}, 64'd1);
            check("stall_hold_count", {48'd0, fetchCount_o}, 64'd4);
        end
        push(16'h0001, 60'hA1);
        push(16'h0002, 60'hA2);
        push(16'h0003, 60'hA3);
        decodeStall_i = 1'b0;
        step();
        check("stall_release_next", {4'd0, instr_o}, 64'hA2);
        repeat (6) step();
        check("stall_count", {48'd0, fetchCount_o}, 64'd7);

        // Branch to 2 while stalled on A1: A1 is dropped.
        decodeStall_i = 1'b1;
        branch(16'h0001);
        step();
        check("pre_branch_instr", {4'd0, instr_o}, 64'hA1);
        branch(16'h0002);
        check("branch_stalled_flush", {63'd0, instrValid_o}, 64'd0);
        push(16'h0002, 60'hA2);
        push(16'h0003, 60'hA3);
        decodeStall_i = 1'b0;
        step();
        check("branch_target_instr", {4'd0, instr_o}, 64'hA2);
        check("branch_target_pc", {48'd0, instrPc_o}, 64'd2);
        repeat (5) step();
        check("branch_count", {48'd0, fetchCount_o}, 64'd9);

        // Miss at 0x0010; wrong-tag write keeps waiting; matching write fills.
        branch(16'h0010);
        repeat (3) step();
        check("miss_valid", {63'd0, instrValid_o}, 64'd0);
        write(16'h0050, 60'h99);
        step();
        check("miss_wrong_tag", {63'd0, instrValid_o}, 64'd0);
        push(16'h0010, 60'h55);
        write(16'h0010, 60'h55);
        check("miss_fill_valid", {63'd0, instrValid_o}, 64'd1);
        check("miss_fill_instr", {4'd0, instr_o}, 64'h55);
        repeat (3) step();
        check("miss_count", {48'd0, fetchCount_o}, 64'd10);

        // Halt with A0 held under stall: delivered on release, then halted.
        decodeStall_i = 1'b1;
        branch(16'h0000);
        step();
        halt_i = 1'b1;
        repeat (2) step();
        check("halt_hold_instr", {4'd0, instr_o}, 64'hA0);
        check("halt_hold_valid", {63'd0, instrValid_o}, 64'd1);
        check("halt_not_yet", {63'd0, halted_o}, 64'd0);
        push(16'h0000, 60'hA0);
        decodeStall_i = 1'b0;
        repeat (2) step();
        check("halted_set", {63'd0, halted_o}, 64'd1);
        check("halted_valid", {63'd0, instrValid_o}, 64'd0);
        check("halted_count", {48'd0, fetchCount_o}, 64'd11);
        push(16'h0001, 60'hA1);
        push(16'h0002, 60'hA2);
        push(16'h0003, 60'hA3);
        halt_i = 1'b0;
        step();
        check("halt_release", {63'd0, halted_o}, 64'd0);
        repeat (6) step();
        check("resume_count", {48'd0, fetchCount_o}, 64'd14);

        // PC wrap 0xFFFF -> 0x0000.
        push(16'hFFFF, 60'hFFF0);
        push(16'h0000, 60'hA0);
        push(16'h0001, 60'hA1);
        push(16'h0002, 60'hA2);
        push(16'h0003, 60'hA3);
        branch(16'hFFFF);
        repeat (8) step();
        check("wrap_count", {48'd0, fetchCount_o}, 64'd19);

        // Asynchronous reset in the middle of a miss.
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_instr", {4'd0, instr_o}, 64'd0);
        check("async_reset_pc", {48'd0, instrPc_o}, 64'd0);
        check("async_reset_count", {48'd0, fetchCount_o}, 64'd0);
        check("async_reset_valid", {63'd0, instrValid_o}, 64'd0);
        step();
        reset_i = 1'b0;
        repeat (4) step();
        check("post_reset_miss", {63'd0, instrValid_o}, 64'd0);
        check("post_reset_count", {48'd0, fetchCount_o}, 64'd0);
        push(16'h0000, 60'h77);
        write(16'h0000, 60'h77);
        check("post_reset_fill", {63'd0, instrValid_o}, 64'd1);
        repeat (3) step();
        check("post_reset_final_count", {48'd0, fetchCount_o}, 64'd1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
